// File: rtl/sync_generator.sv
// Free-running video timing generator: h/v/composite sync, blanking and line/frame pulses.
// A run/stop handshake always lets a started frame finish before the outputs go idle.
module sync_generator #(
    parameter int unsigned CLK_DIV         = 1,
    parameter int unsigned H_TOTAL         = 3180,
    parameter int unsigned H_SYNC          = 235,
    parameter int unsigned H_BACK          = 285,
    parameter int unsigned H_ACTIVE        = 2600,
    parameter int unsigned V_TOTAL         = 262,
    parameter int unsigned V_SYNC          = 3,
    parameter int unsigned V_BACK          = 16,
    parameter int unsigned V_ACTIVE        = 240,
    parameter int unsigned SYNC_ACTIVE_LOW = 1
) (
    input  logic        clk_50mhz_in,
    input  logic        reset_in,
    input  logic        enable_in,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        csync_out,
    output logic        blank_out,
    output logic        line_start_out,
    output logic        frame_start_out,
    output logic [11:0] h_count_out,
    output logic [9:0]  v_count_out,
    output logic        running_out
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned H_W   = 12;
    localparam int unsigned V_W   = 10;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [H_W-1:0]   H_LAST    = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0]   H_SYNC_E  = H_W'(H_SYNC);
    localparam logic [H_W-1:0]   H_ACT_B   = H_W'(H_SYNC + H_BACK);
    localparam logic [H_W-1:0]   H_ACT_E   = H_W'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [V_W-1:0]   V_LAST    = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0]   V_SYNC_E  = V_W'(V_SYNC);
    localparam logic [V_W-1:0]   V_ACT_B   = V_W'(V_SYNC + V_BACK);
    localparam logic [V_W-1:0]   V_ACT_E   = V_W'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic             SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STOPPING
    } state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div, div_nxt;
    logic [H_W-1:0]   h_nxt;
    logic [V_W-1:0]   v_nxt;
    logic             tick, frame_end, run_nxt, hs_act, vs_act;
    logic             hsync_nxt, vsync_nxt, csync_nxt, blank_nxt, line_nxt, frame_nxt;

    // Next position/state; outputs are decoded from the next position so they register aligned with it
    always_comb begin
        state_nxt = state;
        div_nxt   = div;
        h_nxt     = h_count_out;
        v_nxt     = v_count_out;
        tick      = (div == DIV_LAST);
        frame_end = tick && (h_count_out == H_LAST) && (v_count_out == V_LAST);

        if (state != ST_IDLE) begin
            if (tick) begin
                div_nxt = '0;
                if (h_count_out == H_LAST) begin
                    h_nxt = '0;
                    v_nxt = (v_count_out == V_LAST) ? '0 : v_count_out + V_W'(1);
                end else begin
                    h_nxt = h_count_out + H_W'(1);
                end
            end else begin
                div_nxt = div + DIV_W'(1);
            end
        end

        case (state)
            ST_IDLE:     if (enable_in) state_nxt = ST_RUN;
            ST_RUN:      if (!enable_in) state_nxt = ST_STOPPING;
            ST_STOPPING: begin
                if (enable_in)      state_nxt = ST_RUN;
                else if (frame_end) state_nxt = ST_IDLE;
            end
            default:     state_nxt = ST_IDLE;
        endcase

        if (state_nxt == ST_IDLE || state == ST_IDLE) begin
            div_nxt = '0;
            h_nxt   = '0;
            v_nxt   = '0;
        end

        run_nxt   = (state_nxt != ST_IDLE);
        hs_act    = run_nxt && (h_nxt < H_SYNC_E);
        vs_act    = run_nxt && (v_nxt < V_SYNC_E);
        hsync_nxt = hs_act ? ~SYNC_IDLE : SYNC_IDLE;
        vsync_nxt = vs_act ? ~SYNC_IDLE : SYNC_IDLE;
        csync_nxt = (hs_act || vs_act) ? ~SYNC_IDLE : SYNC_IDLE;
        blank_nxt = !(run_nxt && (h_nxt >= H_ACT_B) && (h_nxt < H_ACT_E)
                              && (v_nxt >= V_ACT_B) && (v_nxt < V_ACT_E));
        line_nxt  = run_nxt && (h_nxt == '0);
        frame_nxt = run_nxt && (h_nxt == '0) && (v_nxt == '0);
    end

    always_ff @(posedge clk_50mhz_in) begin
        if (reset_in) begin
            state           <= ST_IDLE;
            div             <= '0;
            h_count_out     <= '0;
            v_count_out     <= '0;
            hsync_out       <= SYNC_IDLE;
            vsync_out       <= SYNC_IDLE;
            csync_out       <= SYNC_IDLE;
            blank_out       <= 1'b1;
            line_start_out  <= 1'b0;
            frame_start_out <= 1'b0;
            running_out     <= 1'b0;
        end else begin
            state           <= state_nxt;
            div             <= div_nxt;
            h_count_out     <= h_nxt;
            v_count_out     <= v_nxt;
            hsync_out       <= hsync_nxt;
            vsync_out       <= vsync_nxt;
            csync_out       <= csync_nxt;
            blank_out       <= blank_nxt;
            line_start_out  <= line_nxt;
            frame_start_out <= frame_nxt;
            running_out     <= run_nxt;
        end
    end

endmodule

// File: tb/tb_sync_generator.sv
// Scoreboard bench for sync_generator on a small timing set (4 clocks/tick, 16x4 raster).
module tb_sync_generator;

    localparam int CD = 4;
    localparam int HT = 16;
    localparam int HS = 2;
    localparam int HB = 2;
    localparam int HA = 8;
    localparam int VT = 4;
    localparam int VS = 1;
    localparam int VB = 1;
    localparam int VA = 2;

    logic        clk_50mhz_in = 1'b0;
    logic        reset_in;
    logic        enable_in;
    logic        hsync_out, vsync_out, csync_out, blank_out;
    logic        line_start_out, frame_start_out, running_out;
    logic [11:0] h_count_out;
    logic [9:0]  v_count_out;

    sync_generator #(
        .CLK_DIV(CD), .H_TOTAL(HT), .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA),
        .V_TOTAL(VT), .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .SYNC_ACTIVE_LOW(1)
    ) dut (
        .clk_50mhz_in   (clk_50mhz_in),
        .reset_in       (reset_in),
        .enable_in      (enable_in),
        .hsync_out      (hsync_out),
        .vsync_out      (vsync_out),
        .csync_out      (csync_out),
        .blank_out      (blank_out),
        .line_start_out (line_start_out),
        .frame_start_out(frame_start_out),
        .h_count_out    (h_count_out),
        .v_count_out    (v_count_out),
        .running_out    (running_out)
    );

    always #10 clk_50mhz_in = ~clk_50mhz_in;

    typedef struct {
        int   cyc;
        int   h;
        int   v;
        logic hs, vs, cs, bl, ls, fs, run;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always @(posedge clk_50mhz_in) cyc <= cyc + 1;

    function automatic exp_t exp_idle(int c);
        exp_t e;
        e.cyc = c; e.h = 0; e.v = 0;
        e.hs = 1'b1; e.vs = 1'b1; e.cs = 1'b1; e.bl = 1'b1;
        e.ls = 1'b0; e.fs = 1'b0; e.run = 1'b0;
        return e;
    endfunction

    // Expected outputs k cycles after the first RUN cycle
    function automatic exp_t exp_run(int c, int k);
        exp_t e;
        e.cyc = c;
        e.h   = (k / CD) % HT;
        e.v   = (k / (CD * HT)) % VT;
        e.hs  = !(e.h < HS);
        e.vs  = !(e.v < VS);
        e.cs  = e.hs & e.vs;
        e.bl  = !(e.h >= HS + HB && e.h < HS + HB + HA && e.v >= VS + VB && e.v < VS + VB + VA);
        e.ls  = (e.h == 0);
        e.fs  = (e.h == 0) && (e.v == 0);
        e.run = 1'b1;
        return e;
    endfunction

    task automatic push_run(input int s, input int k0, input int k1);
        for (int k = k0; k <= k1; k++) sb.push_back(exp_run(s + k, k));
    endtask

    task automatic push_idle(input int c0, input int c1);
        for (int c = c0; c <= c1; c++) sb.push_back(exp_idle(c));
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk_50mhz_in);
    endtask

    // Monitor: compare every expectation due in the current cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_50mhz_in);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_cmp++;
                if (e.cyc != cyc) begin
                    n_err++;
                    $display("FAIL late_check cyc=%0d due=%0d", cyc, e.cyc);
                end else if (int'(h_count_out) != e.h || int'(v_count_out) != e.v ||
                             hsync_out !== e.hs || vsync_out !== e.vs || csync_out !== e.cs ||
                             blank_out !== e.bl || line_start_out !== e.ls ||
                             frame_start_out !== e.fs || running_out !== e.run) begin
                    n_err++;
                    $display("FAIL outputs cyc=%0d got h=%0d v=%0d hs=%b vs=%b cs=%b bl=%b ls=%b fs=%b run=%b required h=%0d v=%0d hs=%b vs=%b cs=%b bl=%b ls=%b fs=%b run=%b",
                             cyc, h_count_out, v_count_out, hsync_out, vsync_out, csync_out,
                             blank_out, line_start_out, frame_start_out, running_out,
                             e.h, e.v, e.hs, e.vs, e.cs, e.bl, e.ls, e.fs, e.run);
                end
            end
        end
    end

    initial begin
        int s;
        int guard;
        reset_in  = 1'b1;
        enable_in = 1'b0;
        repeat (2) @(negedge clk_50mhz_in);

        // Reset held, then released with enable low: stays idle
        push_idle(cyc + 1, cyc + 3);
        repeat (3) @(negedge clk_50mhz_in);
        reset_in = 1'b0;
        push_idle(cyc + 1, cyc + 3);
        repeat (3) @(negedge clk_50mhz_in);

        // Two frames, enable dropped mid second frame: frame completes then idle
        s = cyc + 1;
        push_run(s, 0, 511);
        push_idle(s + 512, s + 520);
        enable_in = 1'b1;
        wait_until(s + 300);
        enable_in = 1'b0;
        wait_until(s + 525);

        // Stop requests withdrawn (long and single-cycle), then reset mid-line with enable held
        s = cyc + 1;
        push_run(s, 0, 400);
        push_idle(s + 401, s + 403);
        push_run(s + 404, 0, 80);
        enable_in = 1'b1;
        wait_until(s + 70);
        enable_in = 1'b0;
        wait_until(s + 130);
        enable_in = 1'b1;
        wait_until(s + 200);
        enable_in = 1'b0;
        @(negedge clk_50mhz_in);
        enable_in = 1'b1;
        wait_until(s + 400);
        reset_in = 1'b1;
        wait_until(s + 403);
        reset_in = 1'b0;
        wait_until(s + 404 + 81);

        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            @(negedge clk_50mhz_in);
            guard++;
        end
        if (sb.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
